// File: rtl/wb_request_arbiter_if.sv
// Request-side bundle of wb_request_arbiter: IFU, LSU and
// wishbone_master request/completion signals plus the watchdog flag.
interface wb_request_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          i_IFU_REQ;
    logic [AW-1:0] i_IFU_ADDR;
    logic [DW-1:0] o_IFU_DATA;
    logic          o_IFU_GNT;

    logic          i_LSU_REQ;
    logic [AW-1:0] i_LSU_ADDR;
    logic [DW-1:0] i_LSU_DATA;
    logic          i_LSU_WE;
    logic [1:0]    i_LSU_HB;
    logic [DW-1:0] o_LSU_DATA;
    logic          o_LSU_GNT;

    logic          o_M_REQ;
    logic [AW-1:0] o_M_ADDR;
    logic [DW-1:0] o_M_DATA;
    logic          o_M_WE;
    logic [1:0]    o_M_HB;
    logic [DW-1:0] i_M_DATA;
    logic          i_M_GNT;

    logic          o_TIMEOUT;

    // Arbiter side
    modport slave (
        input  i_IFU_REQ, i_IFU_ADDR,
        output o_IFU_DATA, o_IFU_GNT,
        input  i_LSU_REQ, i_LSU_ADDR, i_LSU_DATA,
        input  i_LSU_WE, i_LSU_HB,
        output o_LSU_DATA, o_LSU_GNT,
        output o_M_REQ, o_M_ADDR, o_M_DATA, o_M_WE, o_M_HB,
        input  i_M_DATA, i_M_GNT,
        output o_TIMEOUT
    );

    // Requester / bus-master side
    modport master (
        output i_IFU_REQ, i_IFU_ADDR,
        input  o_IFU_DATA, o_IFU_GNT,
        output i_LSU_REQ, i_LSU_ADDR, i_LSU_DATA,
        output i_LSU_WE, i_LSU_HB,
        input  o_LSU_DATA, o_LSU_GNT,
        input  o_M_REQ, o_M_ADDR, o_M_DATA, o_M_WE, o_M_HB,
        output i_M_DATA, i_M_GNT,
        input  o_TIMEOUT
    );
endinterface

// File: rtl/wb_request_arbiter.sv
// Round-robin arbiter sharing the wishbone_master request port between
// the IFU (read-only) and the LSU, one transaction in flight, with watchdog.
module wb_request_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTN,
    wb_request_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OWN_IFU = 2'd1,
        S_OWN_LSU = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_m_req;
    logic                    w_m_req_nxt;
    logic                    r_last_lsu;
    logic                    w_last_lsu_nxt;
    logic                    w_ifu_gnt;
    logic                    w_lsu_gnt;
    logic [ADDR_WIDTH-1:0]   w_m_addr;
    logic [DATA_WIDTH-1:0]   w_m_data;
    logic                    w_m_we;
    logic [1:0]              w_m_hb;

    // State, request and fairness pointer registers
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_state    <= S_IDLE;
            r_m_req    <= 1'b0;
            r_last_lsu <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_m_req    <= w_m_req_nxt;
            r_last_lsu <= w_last_lsu_nxt;
        end
    end

    // Arbitration, completion strobes and next-state decode
    always_comb begin
        w_state_nxt    = r_state;
        w_m_req_nxt    = r_m_req;
        w_last_lsu_nxt = r_last_lsu;
        w_ifu_gnt      = 1'b0;
        w_lsu_gnt      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // LSU wins a tie unless it was the last one served
                if (bus.i_LSU_REQ && (!bus.i_IFU_REQ || !r_last_lsu)) begin
                    w_state_nxt = S_OWN_LSU;
                    w_m_req_nxt = 1'b1;
                end else if (bus.i_IFU_REQ) begin
                    w_state_nxt = S_OWN_IFU;
                    w_m_req_nxt = 1'b1;
                end
            end
            S_OWN_IFU: begin
                if (bus.i_M_GNT) begin
                    w_ifu_gnt      = 1'b1;
                    w_state_nxt    = S_IDLE;
                    w_m_req_nxt    = 1'b0;
                    w_last_lsu_nxt = 1'b0;
                end
            end
            S_OWN_LSU: begin
                if (bus.i_M_GNT) begin
                    w_lsu_gnt      = 1'b1;
                    w_state_nxt    = S_IDLE;
                    w_m_req_nxt    = 1'b0;
                    w_last_lsu_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_m_req_nxt = 1'b0;
            end
        endcase
    end

    // Owner mux onto the master request fields; zero when idle
    always_comb begin
        w_m_addr = '0;
        w_m_data = '0;
        w_m_we   = 1'b0;
        w_m_hb   = 2'b00;
        unique case (r_state)
            S_OWN_IFU: begin
                w_m_addr = bus.i_IFU_ADDR;
                w_m_hb   = 2'b10;
            end
            S_OWN_LSU: begin
                w_m_addr = bus.i_LSU_ADDR;
                w_m_data = bus.i_LSU_DATA;
                w_m_we   = bus.i_LSU_WE;
                w_m_hb   = bus.i_LSU_HB;
            end
            default: ;
        endcase
    end

    assign bus.o_M_REQ    = r_m_req;
    assign bus.o_M_ADDR   = w_m_addr;
    assign bus.o_M_DATA   = w_m_data;
    assign bus.o_M_WE     = w_m_we;
    assign bus.o_M_HB     = w_m_hb;
    assign bus.o_IFU_GNT  = w_ifu_gnt;
    assign bus.o_LSU_GNT  = w_lsu_gnt;
    assign bus.o_IFU_DATA = w_ifu_gnt ? bus.i_M_DATA : '0;
    assign bus.o_LSU_DATA = w_lsu_gnt ? bus.i_M_DATA : '0;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [WDW-1:0] LIM = WDW'(TIMEOUT_CYCLES);

            logic [WDW-1:0] r_wdog;
            logic           r_timeout;

            // Count un-granted owned cycles; held at zero while idle so
            // every new ownership starts from zero
            always_ff @(posedge i_CLK or negedge i_RSTN) begin
                if (!i_RSTN) begin
                    r_wdog    <= '0;
                    r_timeout <= 1'b0;
                end else if (r_state == S_IDLE) begin
                    r_wdog <= '0;
                end else if (!bus.i_M_GNT && (r_wdog != LIM)) begin
                    r_wdog <= r_wdog + 1'b1;
                    if (r_wdog == (LIM - 1'b1)) begin
                        r_timeout <= 1'b1;
                    end
                end
            end

            assign bus.o_TIMEOUT = r_timeout;
        end else begin : g_no_wdog
            assign bus.o_TIMEOUT = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_wb_request_arbiter.sv
// Directed self-checking bench for wb_request_arbiter.
// Watchdog limit shortened to 8 cycles.
module tb_wb_request_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    wb_request_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    wb_request_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_CLK  (clk),
        .i_RSTN (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn           = 1'b0;
        bus.i_IFU_REQ  = 1'b0;
        bus.i_IFU_ADDR = '0;
        bus.i_LSU_REQ  = 1'b0;
        bus.i_LSU_ADDR = '0;
        bus.i_LSU_DATA = '0;
        bus.i_LSU_WE   = 1'b0;
        bus.i_LSU_HB   = 2'b00;
        bus.i_M_DATA   = '0;
        bus.i_M_GNT    = 1'b0;

        // Reset state
        #12;
        check("rst_mreq", bus.o_M_REQ, 0);
        check("rst_maddr", bus.o_M_ADDR, 0);
        check("rst_mhb", bus.o_M_HB, 0);
        check("rst_gnts", {bus.o_IFU_GNT, bus.o_LSU_GNT}, 0);
        check("rst_tmo", bus.o_TIMEOUT, 0);
        #1 rstn = 1'b1;
        tick();

        // 1: LSU write, GNT three cycles after o_M_REQ
        bus.i_LSU_REQ  = 1'b1;
        bus.i_LSU_ADDR = 32'h100;
        bus.i_LSU_DATA = 32'hDEADBEEF;
        bus.i_LSU_WE   = 1'b1;
        bus.i_LSU_HB   = 2'b10;
        check("t1_idle_mreq", bus.o_M_REQ, 0);
        tick();
        check("t1_mreq", bus.o_M_REQ, 1);
        check("t1_we", bus.o_M_WE, 1);
        check("t1_addr", bus.o_M_ADDR, 32'h100);
        check("t1_data", bus.o_M_DATA, 32'hDEADBEEF);
        check("t1_hb", bus.o_M_HB, 2'b10);
        tick();
        tick();
        check("t1_nognt", bus.o_LSU_GNT, 0);
        tick();
        bus.i_M_GNT  = 1'b1;
        bus.i_M_DATA = 32'h0BADF00D;
        #1;
        check("t1_lsu_gnt", bus.o_LSU_GNT, 1);
        check("t1_ifu_gnt", bus.o_IFU_GNT, 0);
        check("t1_lsu_data", bus.o_LSU_DATA, 32'h0BADF00D);
        check("t1_ifu_data", bus.o_IFU_DATA, 0);
        tick();
        bus.i_M_GNT   = 1'b0;
        bus.i_LSU_REQ = 1'b0;
        bus.i_LSU_WE  = 1'b0;
        #1;
        check("t1_done_mreq", bus.o_M_REQ, 0);
        check("t1_done_gnt", bus.o_LSU_GNT, 0);

        // 2: tie alternation after reset, LSU first
        rstn = 1'b0;
        #2 rstn = 1'b1;
        bus.i_IFU_REQ  = 1'b1;
        bus.i_IFU_ADDR = 32'h200;
        bus.i_LSU_REQ  = 1'b1;
        bus.i_LSU_ADDR = 32'h300;
        bus.i_LSU_DATA = 32'h11112222;
        bus.i_LSU_HB   = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_mreq", bus.o_M_REQ, 1);
            check("t2_addr", bus.o_M_ADDR, (i % 2 == 0) ? 32'h300 : 32'h200);
            check("t2_hb", bus.o_M_HB, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("t2_mdata", bus.o_M_DATA, (i % 2 == 0) ? 32'h11112222 : 0);
            bus.i_M_GNT  = 1'b1;
            bus.i_M_DATA = 32'hA0 + i;
            #1;
            check("t2_lsu_gnt", bus.o_LSU_GNT, (i % 2 == 0) ? 1 : 0);
            check("t2_ifu_gnt", bus.o_IFU_GNT, (i % 2 == 0) ? 0 : 1);
            tick();
            bus.i_M_GNT = 1'b0;
            #1;
            check("t2_idle_mreq", bus.o_M_REQ, 0);
        end

        // 3: LSU arrives mid IFU transaction, IFU undisturbed
        bus.i_IFU_REQ = 1'b0;
        bus.i_LSU_REQ = 1'b0;
        tick();
        bus.i_IFU_REQ  = 1'b1;
        bus.i_IFU_ADDR = 32'h400;
        tick();
        check("t3_ifu_addr", bus.o_M_ADDR, 32'h400);
        bus.i_LSU_REQ  = 1'b1;
        bus.i_LSU_ADDR = 32'h500;
        bus.i_LSU_DATA = 32'h55AA55AA;
        bus.i_LSU_WE   = 1'b1;
        bus.i_LSU_HB   = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_addr", bus.o_M_ADDR, 32'h400);
            check("t3_hold_we", bus.o_M_WE, 0);
            check("t3_hold_lgnt", bus.o_LSU_GNT, 0);
        end
        bus.i_M_GNT  = 1'b1;
        bus.i_M_DATA = 32'hCAFEF00D;
        #1;
        check("t3_ifu_gnt", bus.o_IFU_GNT, 1);
        check("t3_ifu_data", bus.o_IFU_DATA, 32'hCAFEF00D);
        check("t3_lsu_data", bus.o_LSU_DATA, 0);
        tick();
        bus.i_M_GNT   = 1'b0;
        bus.i_IFU_REQ = 1'b0;
        #1;
        check("t3_gap_mreq", bus.o_M_REQ, 0);
        tick();
        check("t3_lsu_mreq", bus.o_M_REQ, 1);
        check("t3_lsu_addr", bus.o_M_ADDR, 32'h500);
        check("t3_lsu_we", bus.o_M_WE, 1);
        bus.i_M_GNT = 1'b1;
        #1;
        check("t3_lsu_gnt", bus.o_LSU_GNT, 1);
        tick();
        bus.i_M_GNT   = 1'b0;
        bus.i_LSU_REQ = 1'b0;
        bus.i_LSU_WE  = 1'b0;

        // 4: watchdog at 8 owned cycles without GNT
        bus.i_IFU_REQ  = 1'b1;
        bus.i_IFU_ADDR = 32'h600;
        tick();
        check("t4_own", bus.o_M_REQ, 1);
        for (int i = 0; i < 7; i++) tick();
        check("t4_tmo_7", bus.o_TIMEOUT, 0);
        tick();
        check("t4_tmo_8", bus.o_TIMEOUT, 1);
        tick();
        tick();
        bus.i_M_GNT = 1'b1;
        #1;
        check("t4_late_gnt", bus.o_IFU_GNT, 1);
        tick();
        bus.i_M_GNT   = 1'b0;
        bus.i_IFU_REQ = 1'b0;
        bus.i_LSU_REQ = 1'b1;
        bus.i_LSU_ADDR = 32'h700;
        #1;
        check("t4_sticky", bus.o_TIMEOUT, 1);
        tick();
        check("t4_next_addr", bus.o_M_ADDR, 32'h700);
        bus.i_M_GNT = 1'b1;
        #1;
        check("t4_next_gnt", bus.o_LSU_GNT, 1);
        tick();
        bus.i_M_GNT   = 1'b0;
        bus.i_LSU_REQ = 1'b0;
        #1;
        check("t4_sticky2", bus.o_TIMEOUT, 1);

        // 5: asynchronous reset during OWN_LSU
        bus.i_LSU_REQ  = 1'b1;
        bus.i_LSU_ADDR = 32'h800;
        tick();
        check("t5_own", bus.o_M_REQ, 1);
        #2;
        rstn        = 1'b0;
        bus.i_M_GNT = 1'b1;
        #1;
        check("t5_rst_mreq", bus.o_M_REQ, 0);
        check("t5_rst_gnt", {bus.o_IFU_GNT, bus.o_LSU_GNT}, 0);
        check("t5_rst_addr", bus.o_M_ADDR, 0);
        check("t5_rst_tmo", bus.o_TIMEOUT, 0);
        bus.i_M_GNT = 1'b0;
        #1 rstn = 1'b1;
        bus.i_IFU_REQ  = 1'b1;
        bus.i_IFU_ADDR = 32'h900;
        tick();
        check("t5_tie_lsu", bus.o_M_ADDR, 32'h800);
        bus.i_M_GNT = 1'b1;
        #1;
        check("t5_tie_gnt", bus.o_LSU_GNT, 1);
        tick();
        bus.i_M_GNT   = 1'b0;
        bus.i_IFU_REQ = 1'b0;
        bus.i_LSU_REQ = 1'b0;
        tick();

        // 6: stray GNT while idle, then owner dropping REQ early
        bus.i_M_GNT = 1'b1;
        #1;
        check("t6_stray_gnt", {bus.o_IFU_GNT, bus.o_LSU_GNT}, 0);
        tick();
        check("t6_stray_mreq", bus.o_M_REQ, 0);
        bus.i_M_GNT    = 1'b0;
        bus.i_IFU_REQ  = 1'b1;
        bus.i_IFU_ADDR = 32'hA00;
        tick();
        check("t6_own_ifu", bus.o_M_ADDR, 32'hA00);
        bus.i_IFU_REQ = 1'b0;
        tick();
        check("t6_drop_mreq", bus.o_M_REQ, 1);
        bus.i_M_GNT = 1'b1;
        #1;
        check("t6_drop_gnt", bus.o_IFU_GNT, 1);
        tick();
        bus.i_M_GNT = 1'b0;
        #1;
        check("t6_end_mreq", bus.o_M_REQ, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
